sm83_sequencer: RTL and testbench

Cycle sequencer for the sm83 core. It counts T-states and M-cycles and runs the fetch/execute, HALT and interrupt-dispatch state machine. Every T-state it drives the datapath bus selects (`db_sel`, `addr_sel`), memory strobes, IR load and commit strobes from the instruction decoder's per-M-cycle request. It sits between `decoder` and the `sm83` register/bus datapath.

---
 rtl/sm83_pkg.sv | 57 +++++
 rtl/sm83_sequencer_if.sv | 50 +++++
 rtl/sm83_tstate_counter.sv | 27 ++
 rtl/sm83_sequencer.sv | 175 +++++++++++++++++
 tb/tb_sm83_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sm83_pkg.sv
// Shared types and constants for the sm83 cycle sequencer and its datapath.
package sm83_pkg;

  // Data-bus source select driven into the register/bus datapath.
  typedef enum logic [3:0] {
    DB_A    = 4'd0,
    DB_B    = 4'd1,
    DB_C    = 4'd2,
    DB_D    = 4'd3,
    DB_E    = 4'd4,
    DB_H    = 4'd5,
    DB_L    = 4'd6,
    DB_F    = 4'd7,
    DB_MEM  = 4'd8,
    DB_PCH  = 4'd9,
    DB_PCL  = 4'd10,
    DB_SPH  = 4'd11,
    DB_SPL  = 4'd12,
    DB_ALU  = 4'd13,
    DB_IMM  = 4'd14,
    DB_ZERO = 4'd15
  } s_db_t;

  // Address-bus source select; ADDR_HI_* are the 0xFF00-page forms.
  typedef enum logic [2:0] {
    ADDR_PC   = 3'd0,
    ADDR_SP   = 3'd1,
    ADDR_HL   = 3'd2,
    ADDR_BC   = 3'd3,
    ADDR_DE   = 3'd4,
    ADDR_WZ   = 3'd5,
    ADDR_HI_C = 3'd6,
    ADDR_HI_Z = 3'd7
  } s_addr_t;

  // Sequencer top-level state.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2,
    S_IRQ   = 2'd3
  } seq_state_t;

  // T-state encodings as seen on t_state.
  localparam logic [1:0] T1 = 2'd0;
  localparam logic [1:0] T2 = 2'd1;
  localparam logic [1:0] T3 = 2'd2;
  localparam logic [1:0] T4 = 2'd3;

  localparam logic [2:0] M_CYCLE_MAX = 3'd7;

  // M-cycle index step that sticks at the top value instead of wrapping.
  function automatic logic [2:0] m_inc_sat(input logic [2:0] m);
    return (m == M_CYCLE_MAX) ? m : m + 3'd1;
  endfunction

endpackage

// File: rtl/sm83_sequencer_if.sv
// Decoder request / datapath control bundle around the sm83 sequencer.
// Handshake: there is no valid/ready pair; the dec_* request is qualified by
// the M-cycle itself and must be held stable from T1 through T4, and every
// control output is valid for the T-state shown on t_state.
interface sm83_sequencer_if;
  import sm83_pkg::*;

  // Decoder request and core status
  s_db_t      dec_db_sel;
  s_addr_t    dec_addr_sel;
  logic       dec_mem_rd;
  logic       dec_mem_wr;
  logic       dec_idu_en;
  logic       dec_last_m;
  logic       dec_halt;
  logic       ir_is_cb;
  logic       ime;
  logic       irq_pending;

  // Sequencer outputs
  logic [1:0] t_state;
  logic [2:0] m_cycle;
  s_db_t      db_sel;
  s_addr_t    addr_sel;
  logic       mem_rd;
  logic       write;
  logic       ir_load;
  logic       reg_we;
  logic       idu_en;
  logic       idu_dec;
  logic       cb_mode;
  logic       halted;
  logic       irq_ack;
  seq_state_t dbg_state;

  modport master (
    input  dec_db_sel, dec_addr_sel, dec_mem_rd, dec_mem_wr, dec_idu_en,
           dec_last_m, dec_halt, ir_is_cb, ime, irq_pending,
    output t_state, m_cycle, db_sel, addr_sel, mem_rd, write, ir_load,
           reg_we, idu_en, idu_dec, cb_mode, halted, irq_ack, dbg_state
  );

  modport slave (
    output dec_db_sel, dec_addr_sel, dec_mem_rd, dec_mem_wr, dec_idu_en,
           dec_last_m, dec_halt, ir_is_cb, ime, irq_pending,
    input  t_state, m_cycle, db_sel, addr_sel, mem_rd, write, ir_load,
           reg_we, idu_en, idu_dec, cb_mode, halted, irq_ack, dbg_state
  );

endinterface

// File: rtl/sm83_tstate_counter.sv
// Free-running T1..T4 counter; m_end marks T4, the last clock of an M-cycle.
module sm83_tstate_counter
  import sm83_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] t_state,
  output logic       m_end
);

  logic [1:0] t_state_q, t_state_d;

  // Next T-state: plain 2-bit wrap, T4 rolls over to T1.
  always_comb begin
    t_state_d = t_state_q + 2'd1;
  end

  // T-state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) t_state_q <= T1;
    else        t_state_q <= t_state_d;
  end

  assign t_state = t_state_q;
  assign m_end   = (t_state_q == T4);

endmodule

// File: rtl/sm83_sequencer.sv
// sm83 cycle sequencer: fetch/execute, HALT and interrupt dispatch control.
// All control outputs are combinational from registered state plus the
// decoder request; state, m_cycle and cb_mode only move on the T4->T1 edge.
module sm83_sequencer
  import sm83_pkg::*;
#(
  parameter int IRQ_MCYCLES = 5
) (
  input logic              clk,
  input logic              rst_n,
  sm83_sequencer_if.master bus
);

  localparam logic [2:0] IRQ_LAST_M = 3'(IRQ_MCYCLES - 1);

  logic [1:0] t_state;
  logic       m_end;

  seq_state_t state_q, state_d;
  logic [2:0] m_cycle_q, m_cycle_d;
  logic       cb_mode_q, cb_mode_d;

  s_db_t      db_sel;
  s_addr_t    addr_sel;
  logic       mem_rd;
  logic       write;
  logic       ir_load;
  logic       reg_we;
  logic       idu_en;
  logic       idu_dec;
  logic       irq_ack;

  logic       wr_window;
  logic       irq_take;

  sm83_tstate_counter u_tstate (
    .clk     (clk),
    .rst_n   (rst_n),
    .t_state (t_state),
    .m_end   (m_end)
  );

  // Writes are held off T1 so the address settles first and drop before T4.
  assign wr_window = (t_state == T2) || (t_state == T3);
  // A CB prefix never ends an instruction, so it cannot be interrupted.
  assign irq_take  = bus.dec_last_m & bus.ime & bus.irq_pending & ~bus.ir_is_cb;

  // Next-state and per-T-state control decode.
  always_comb begin
    state_d   = state_q;
    m_cycle_d = m_cycle_q;
    cb_mode_d = cb_mode_q;
    db_sel    = DB_A;
    addr_sel  = ADDR_PC;
    mem_rd    = 1'b0;
    write     = 1'b0;
    ir_load   = 1'b0;
    reg_we    = 1'b0;
    idu_en    = 1'b0;
    idu_dec   = 1'b0;
    irq_ack   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_rd  = 1'b1;
        ir_load = m_end;
        idu_en  = m_end;
        if (m_end) begin
          state_d   = S_EXEC;
          m_cycle_d = 3'd0;
        end
      end

      S_EXEC: begin
        db_sel = bus.dec_db_sel;
        reg_we = m_end;
        if (bus.dec_last_m) begin
          if (irq_take) begin
            // Final ALU/writeback still happens, but no opcode fetch.
            if (m_end) state_d = S_IRQ;
          end else begin
            // Overlapped fetch of the next opcode from PC.
            mem_rd  = 1'b1;
            ir_load = m_end;
            idu_en  = m_end;
            if (m_end && bus.dec_halt) state_d = S_HALT;
          end
          if (m_end) begin
            m_cycle_d = 3'd0;
            cb_mode_d = bus.ir_is_cb;
          end
        end else begin
          addr_sel = bus.dec_addr_sel;
          mem_rd   = bus.dec_mem_rd;
          write    = bus.dec_mem_wr & wr_window;
          idu_en   = bus.dec_idu_en & m_end;
          if (m_end) m_cycle_d = m_inc_sat(m_cycle_q);
        end
      end

      S_HALT: begin
        // IR already holds the opcode after HALT; leave via EXEC without a fetch.
        if (m_end && bus.irq_pending) begin
          state_d   = bus.ime ? S_IRQ : S_EXEC;
          m_cycle_d = 3'd0;
        end
      end

      S_IRQ: begin
        // Push PC high then low onto the stack, pre-decrementing SP.
        case (m_cycle_q)
          3'd1: begin
            addr_sel = ADDR_SP;
            idu_dec  = m_end;
          end
          3'd2: begin
            addr_sel = ADDR_SP;
            db_sel   = DB_PCH;
            write    = wr_window;
            idu_dec  = m_end;
          end
          3'd3: begin
            addr_sel = ADDR_SP;
            db_sel   = DB_PCL;
            write    = wr_window;
          end
          default: ;
        endcase
        if (m_cycle_q == IRQ_LAST_M) begin
          irq_ack = m_end;
          if (m_end) begin
            state_d   = S_FETCH;
            m_cycle_d = 3'd0;
          end
        end else if (m_end) begin
          m_cycle_d = m_cycle_q + 3'd1;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      m_cycle_q <= 3'd0;
      cb_mode_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_cycle_q <= m_cycle_d;
      cb_mode_q <= cb_mode_d;
    end
  end

  assign bus.t_state   = t_state;
  assign bus.m_cycle   = m_cycle_q;
  assign bus.db_sel    = db_sel;
  assign bus.addr_sel  = addr_sel;
  // Reset state is S_FETCH; keep the read quiet until reset is released.
  assign bus.mem_rd    = mem_rd & rst_n;
  assign bus.write     = write;
  assign bus.ir_load   = ir_load;
  assign bus.reg_we    = reg_we;
  assign bus.idu_en    = idu_en;
  assign bus.idu_dec   = idu_dec;
  assign bus.cb_mode   = cb_mode_q;
  assign bus.halted    = (state_q == S_HALT);
  assign bus.irq_ack   = irq_ack;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_sm83_sequencer.sv
// Bench for sm83_sequencer: scenario tasks drive one decoder request per
// M-cycle, push the four expected T-state output vectors, then compare.
module tb_sm83_sequencer;
  import sm83_pkg::*;

  localparam int W = 21;

  // T4 strobe groups: {ir_load, reg_we, idu_en, idu_dec, irq_ack}
  localparam logic [4:0] T4_NONE      = 5'b00000;
  localparam logic [4:0] T4_FETCH     = 5'b10100;
  localparam logic [4:0] T4_OVL       = 5'b11100;
  localparam logic [4:0] T4_REGWE     = 5'b01000;
  localparam logic [4:0] T4_REGWE_IDU = 5'b01100;
  localparam logic [4:0] T4_DEC       = 5'b00010;
  localparam logic [4:0] T4_ACK       = 5'b00001;

  typedef struct packed {
    s_db_t   db;
    s_addr_t a;
    logic    rd, wr, idu, last, halt, cb, ime, irq;
  } stim_t;

  typedef struct packed {
    logic [2:0] m;
    s_db_t      db;
    s_addr_t    a;
    logic       rd, wr;
    logic [4:0] t4;
    logic       cb, hl;
  } mexp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [W-1:0] exp_q[$];

  sm83_sequencer_if bus_if();

  sm83_sequencer #(.IRQ_MCYCLES(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic stim_t st(input s_db_t db, input s_addr_t a, input logic rd,
                               input logic wr, input logic idu, input logic last,
                               input logic halt, input logic cb, input logic ime,
                               input logic irq);
    stim_t s;
    s.db = db; s.a = a; s.rd = rd; s.wr = wr; s.idu = idu; s.last = last;
    s.halt = halt; s.cb = cb; s.ime = ime; s.irq = irq;
    return s;
  endfunction

  function automatic mexp_t me(input logic [2:0] m, input s_db_t db, input s_addr_t a,
                               input logic rd, input logic wr, input logic [4:0] t4,
                               input logic cb, input logic hl);
    mexp_t e;
    e.m = m; e.db = db; e.a = a; e.rd = rd; e.wr = wr; e.t4 = t4; e.cb = cb; e.hl = hl;
    return e;
  endfunction

  // Expected output vector for T-state t of an M-cycle described by e.
  function automatic logic [W-1:0] ev(input int t, input mexp_t e);
    logic       is_t4;
    logic       wr;
    logic [1:0] tt;
    tt    = 2'(t);
    is_t4 = (t == 3);
    wr    = e.wr && (t == 1 || t == 2);
    return {tt, e.m, e.db, e.a, e.rd, wr, e.t4[4:1] & {4{is_t4}}, e.cb, e.hl,
            e.t4[0] & is_t4};
  endfunction

  function automatic logic [W-1:0] obs();
    return {bus_if.t_state, bus_if.m_cycle, bus_if.db_sel, bus_if.addr_sel,
            bus_if.mem_rd, bus_if.write, bus_if.ir_load, bus_if.reg_we,
            bus_if.idu_en, bus_if.idu_dec, bus_if.cb_mode, bus_if.halted,
            bus_if.irq_ack};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_m(input stim_t s);
    bus_if.dec_db_sel   = s.db;
    bus_if.dec_addr_sel = s.a;
    bus_if.dec_mem_rd   = s.rd;
    bus_if.dec_mem_wr   = s.wr;
    bus_if.dec_idu_en   = s.idu;
    bus_if.dec_last_m   = s.last;
    bus_if.dec_halt     = s.halt;
    bus_if.ir_is_cb     = s.cb;
    bus_if.ime          = s.ime;
    bus_if.irq_pending  = s.irq;
  endtask

  task automatic push_m(input mexp_t e);
    for (int t = 0; t < 4; t++) exp_q.push_back(ev(t, e));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [W-1:0] got, want;
    rst_n = 1'b0;
    drive_m(st(DB_ALU, ADDR_HL, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(ev(0, me(3'd0, DB_A, ADDR_PC, 1'b0, 1'b0, T4_NONE, 1'b0, 1'b0)));
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL reset_outputs got=%h want=%h", got, want);
      end
    end
    checks++;
    if (bus_if.dbg_state !== S_FETCH) begin
      errors++; $display("FAIL reset_state got=%0d want=%0d", bus_if.dbg_state, S_FETCH);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_nop_stream();
    stim_t s[$]; mexp_t e[$];
    logic [W-1:0] got, want;
    for (int i = 0; i < 4; i++)
      s.push_back(st(DB_ALU, ADDR_HL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    e.push_back(me(3'd0, DB_A, ADDR_PC, 1'b1, 1'b0, T4_FETCH, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++)
      e.push_back(me(3'd0, DB_ALU, ADDR_PC, 1'b1, 1'b0, T4_OVL, 1'b0, 1'b0));
    for (int i = 0; i < s.size(); i++) begin
      drive_m(s[i]); push_m(e[i]);
      for (int t = 0; t < 4; t++) begin
        @(negedge clk);
        got = obs(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
          errors++; $display("FAIL nop_stream m%0d t%0d got=%h want=%h", i, t, got, want);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_exec_seq();
    stim_t s[$]; mexp_t e[$];
    logic [W-1:0] got, want;
    // LD (HL),r: write M-cycle, then overlapped fetch with rd/wr requests ignored
    s.push_back(st(DB_B, ADDR_HL, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    e.push_back(me(3'd0, DB_B, ADDR_HL, 1'b0, 1'b1, T4_REGWE, 1'b0, 1'b0));
    s.push_back(st(DB_ALU, ADDR_HL, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    e.push_back(me(3'd1, DB_ALU, ADDR_PC, 1'b1, 1'b0, T4_OVL, 1'b0, 1'b0));
    // single-M instruction whose last M-cycle asks for a write
    s.push_back(st(DB_C, ADDR_DE, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    e.push_back(me(3'd0, DB_C, ADDR_PC, 1'b1, 1'b0, T4_OVL, 1'b0, 1'b0));
    // LD A,(HL+): read with IDU step, then fetch
    s.push_back(st(DB_MEM, ADDR_HL, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    e.push_back(me(3'd0, DB_MEM, ADDR_HL, 1'b1, 1'b0, T4_REGWE_IDU, 1'b0, 1'b0));
    s.push_back(st(DB_ALU, ADDR_BC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    e.push_back(me(3'd1, DB_ALU, ADDR_PC, 1'b1, 1'b0, T4_OVL, 1'b0, 1'b0));
    for (int i = 0; i < s.size(); i++) begin
      drive_m(s[i]); push_m(e[i]);
      for (int t = 0; t < 4; t++) begin
        @(negedge clk);
        got = obs(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
          errors++; $display("FAIL exec_seq m%0d t%0d got=%h want=%h", i, t, got, want);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_m_saturate();
    stim_t s[$]; mexp_t e[$];
    logic [W-1:0] got, want;
    for (int i = 0; i < 9; i++) begin
      s.push_back(st(DB_D, ADDR_WZ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      e.push_back(me((i < 7) ? 3'(i) : 3'd7, DB_D, ADDR_WZ, 1'b1, 1'b0, T4_REGWE, 1'b0, 1'b0));
    end
    s.push_back(st(DB_E, ADDR_WZ, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    e.push_back(me(3'd7, DB_E, ADDR_PC, 1'b1, 1'b0, T4_OVL, 1'b0, 1'b0));
    for (int i = 0; i < s.size(); i++) begin
      drive_m(s[i]); push_m(e[i]);
      for (int t = 0; t < 4; t++) begin
        @(negedge clk);
        got = obs(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
          errors++; $display("FAIL m_saturate m%0d t%0d got=%h want=%h", i, t, got, want);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_halt();
    stim_t s[$]; mexp_t e[$];
    logic [W-1:0] got, want;
    s.push_back(st(DB_H, ADDR_PC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    e.push_back(me(3'd0, DB_H, ADDR_PC, 1'b1, 1'b0, T4_OVL, 1'b0, 1'b0));
    // decoder noise while halted must not reach the bus
    for (int i = 0; i < 3; i++) begin
      s.push_back(st(DB_ALU, ADDR_HL, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      e.push_back(me(3'd0, DB_A, ADDR_PC, 1'b0, 1'b0, T4_NONE, 1'b0, 1'b1));
    end
    s.push_back(st(DB_ALU, ADDR_HL, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    e.push_back(me(3'd0, DB_A, ADDR_PC, 1'b0, 1'b0, T4_NONE, 1'b0, 1'b1));
    // wake with ime=0: straight into EXEC M0, no fetch cycle in between
    s.push_back(st(DB_ALU, ADDR_SP, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    e.push_back(me(3'd0, DB_ALU, ADDR_PC, 1'b1, 1'b0, T4_OVL, 1'b0, 1'b0));
    for (int i = 0; i < s.size(); i++) begin
      drive_m(s[i]); push_m(e[i]);
      for (int t = 0; t < 4; t++) begin
        @(negedge clk);
        got = obs(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
          errors++; $display("FAIL halt m%0d t%0d got=%h want=%h", i, t, got, want);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_irq_dispatch();
    stim_t s[$]; mexp_t e[$];
    logic [W-1:0] got, want;
    // pending in a non-last M-cycle is ignored
    s.push_back(st(DB_B, ADDR_HL, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    e.push_back(me(3'd0, DB_B, ADDR_HL, 1'b1, 1'b0, T4_REGWE, 1'b0, 1'b0));
    // taken at last M: reg_we only, no fetch
    s.push_back(st(DB_ALU, ADDR_HL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    e.push_back(me(3'd1, DB_ALU, ADDR_PC, 1'b0, 1'b0, T4_REGWE, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++)
      s.push_back(st(DB_C, ADDR_HL, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    e.push_back(me(3'd0, DB_A,   ADDR_PC, 1'b0, 1'b0, T4_NONE, 1'b0, 1'b0));
    e.push_back(me(3'd1, DB_A,   ADDR_SP, 1'b0, 1'b0, T4_DEC,  1'b0, 1'b0));
    e.push_back(me(3'd2, DB_PCH, ADDR_SP, 1'b0, 1'b1, T4_DEC,  1'b0, 1'b0));
    e.push_back(me(3'd3, DB_PCL, ADDR_SP, 1'b0, 1'b1, T4_NONE, 1'b0, 1'b0));
    e.push_back(me(3'd4, DB_A,   ADDR_PC, 1'b0, 1'b0, T4_ACK,  1'b0, 1'b0));
    s.push_back(st(DB_ALU, ADDR_HL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    e.push_back(me(3'd0, DB_A, ADDR_PC, 1'b1, 1'b0, T4_FETCH, 1'b0, 1'b0));
    s.push_back(st(DB_ALU, ADDR_PC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    e.push_back(me(3'd0, DB_ALU, ADDR_PC, 1'b1, 1'b0, T4_OVL, 1'b0, 1'b0));
    for (int i = 0; i < s.size(); i++) begin
      drive_m(s[i]); push_m(e[i]);
      for (int t = 0; t < 4; t++) begin
        @(negedge clk);
        got = obs(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
          errors++; $display("FAIL irq_dispatch m%0d t%0d got=%h want=%h", i, t, got, want);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_cb_prefix();
    stim_t s[$]; mexp_t e[$];
    logic [W-1:0] got, want;
    // IR=0xCB at last M with an enabled IRQ pending: deferred, fetch goes ahead
    s.push_back(st(DB_ALU, ADDR_PC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
    e.push_back(me(3'd0, DB_ALU, ADDR_PC, 1'b1, 1'b0, T4_OVL, 1'b0, 1'b0));
    s.push_back(st(DB_B, ADDR_HL, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    e.push_back(me(3'd0, DB_B, ADDR_HL, 1'b1, 1'b0, T4_REGWE, 1'b1, 1'b0));
    s.push_back(st(DB_ALU, ADDR_HL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    e.push_back(me(3'd1, DB_ALU, ADDR_PC, 1'b1, 1'b0, T4_OVL, 1'b1, 1'b0));
    s.push_back(st(DB_ALU, ADDR_PC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    e.push_back(me(3'd0, DB_ALU, ADDR_PC, 1'b1, 1'b0, T4_OVL, 1'b0, 1'b0));
    for (int i = 0; i < s.size(); i++) begin
      drive_m(s[i]); push_m(e[i]);
      for (int t = 0; t < 4; t++) begin
        @(negedge clk);
        got = obs(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
          errors++; $display("FAIL cb_prefix m%0d t%0d got=%h want=%h", i, t, got, want);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_mid_write();
    mexp_t wm, fm;
    logic [W-1:0] got, want;
    wm = me(3'd0, DB_B, ADDR_HL, 1'b0, 1'b1, T4_REGWE, 1'b0, 1'b0);
    drive_m(st(DB_B, ADDR_HL, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(0, wm));
    exp_q.push_back(ev(1, wm));
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL mid_write t%0d got=%h want=%h", t, got, want);
      end
      if (t == 0) begin @(posedge clk); #1; end
    end
    // reset lands during T2 of the write
    #2 rst_n = 1'b0;
    exp_q.push_back(ev(0, me(3'd0, DB_A, ADDR_PC, 1'b0, 1'b0, T4_NONE, 1'b0, 1'b0)));
    #1;
    got = obs(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL mid_write_reset got=%h want=%h", got, want);
    end
    checks++;
    if (bus_if.dbg_state !== S_FETCH) begin
      errors++; $display("FAIL mid_write_state got=%0d want=%0d", bus_if.dbg_state, S_FETCH);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    fm = me(3'd0, DB_A, ADDR_PC, 1'b1, 1'b0, T4_FETCH, 1'b0, 1'b0);
    drive_m(st(DB_ALU, ADDR_HL, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    push_m(fm);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL post_reset_fetch t%0d got=%h want=%h", t, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    test_reset();
    test_nop_stream();
    test_exec_seq();
    test_m_saturate();
    test_halt();
    test_irq_dispatch();
    test_cb_prefix();
    test_reset_mid_write();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL exp_q_drain got=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Run-time bound in case a scenario stalls.
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
